// File: rtl/reg_file_async_reset.sv
// Register file with async-reset entries, one synchronous write port and two
// combinational read ports; entry 0 always reads as zero.
module reg_file_async_reset #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [WIDTH-1:0]  rs1_data,
    output logic [WIDTH-1:0]  rs2_data
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             wr_live;
    logic             bypass_on;

    // A write only counts outside reset and never targets x0.
    assign wr_live   = wr_en && !rst && (wr_addr != '0);
    assign bypass_on = (BYPASS != 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (bypass_on && wr_live && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (bypass_on && wr_live && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end
    end

endmodule
